// File: rtl/llr_ctrl_pkg.sv
// Shared types and defaults for the min-sum decoder control path.
// Holds the controller state enum, iteration-width helper and size defaults.
package llr_ctrl_pkg;

  localparam int N_V_DEF    = 44;
  localparam int N_ITER_DEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    ITER,
    OUT
  } ctrl_state_t;

  function automatic int iter_w(input int n_iter);
    return $clog2(n_iter + 1);
  endfunction

endpackage

// File: rtl/cw_fifo.sv
// Two-entry codeword FIFO with registered occupancy count.
// Ports: clk, rst_n, push_i/wdata_i, pop_i, full_o, empty_o, head_o.
module cw_fifo #(
  parameter int W = 44
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem0_q;
  logic [W-1:0] mem1_q;
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign head_o  = rd_q ? mem1_q : mem0_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q <= '0;
      mem1_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_q) mem1_q <= wdata_i;
        else      mem0_q <= wdata_i;
        wr_q <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      // Simultaneous push and pop leave the count unchanged.
      if (do_push && !do_pop)      cnt_q <= cnt_q + 2'd1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 2'd1;
    end
  end

endmodule

// File: rtl/llr_decode_ctrl.sv
// Sequencer for the min-sum decoder: buffers codewords, runs init/iterations,
// returns decoded word, iteration count and convergence flag downstream.
module llr_decode_ctrl
  import llr_ctrl_pkg::*;
#(
  parameter int N_V        = N_V_DEF,
  parameter int N_ITER     = N_ITER_DEF,
  parameter bit EARLY_STOP = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_V-1:0]              in_cw,
  output logic [N_V-1:0]              dec_cw,
  output logic                        dec_init,
  output logic                        dec_iter_en,
  output logic [iter_w(N_ITER)-1:0]   dec_iter_idx,
  input  logic [N_V-1:0]              dec_hard,
  input  logic                        dec_syn_ok,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_V-1:0]              out_cw,
  output logic [iter_w(N_ITER)-1:0]   out_iters,
  output logic                        out_converged
);

  localparam int IW = iter_w(N_ITER);

  ctrl_state_t   state_q, state_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [N_V-1:0] dec_cw_q;
  logic [N_V-1:0] out_cw_q;
  logic [IW-1:0] out_iters_q;
  logic          out_conv_q;

  logic          full;
  logic          empty;
  logic [N_V-1:0] head;
  logic          push;
  logic          pop;
  logic          iter_en;
  logic          cap;
  logic          term;

  assign in_ready = rst && !full;
  assign push     = in_valid && in_ready;

  cw_fifo #(
    .W (N_V)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .wdata_i (in_cw),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign term = (iter_q == IW'(N_ITER)) || (EARLY_STOP && dec_syn_ok);

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    pop     = 1'b0;
    iter_en = 1'b0;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = INIT;
        end
      end
      INIT: begin
        iter_d  = '0;
        state_d = ITER;
      end
      ITER: begin
        if (term) begin
          cap     = 1'b1;
          state_d = OUT;
        end else begin
          iter_en = 1'b1;
          iter_d  = iter_q + IW'(1);
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      iter_q      <= '0;
      dec_cw_q    <= '0;
      out_cw_q    <= '0;
      out_iters_q <= '0;
      out_conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      if (pop) dec_cw_q <= head;
      if (cap) begin
        out_cw_q    <= dec_hard;
        out_iters_q <= iter_q;
        out_conv_q  <= dec_syn_ok;
      end
    end
  end

  assign dec_cw        = dec_cw_q;
  assign dec_init      = (state_q == INIT);
  assign dec_iter_en   = iter_en;
  assign dec_iter_idx  = iter_q;
  assign out_valid     = (state_q == OUT);
  assign out_cw        = out_cw_q;
  assign out_iters     = out_iters_q;
  assign out_converged = out_conv_q;

endmodule

// File: tb/tb_llr_decode_ctrl.sv
// Directed bench for llr_decode_ctrl (early stop on and off instances).
// Decoder is modelled as dec_hard = dec_cw ^ hmask.
module tb_llr_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_valid1;
  logic [43:0] in_cw;
  logic        dec_syn_ok;
  logic        out_ready;
  logic        out_ready1;
  logic [43:0] hmask;

  logic        in_ready, in_ready1;
  logic [43:0] dec_cw, dec_cw1;
  logic        dec_init, dec_init1;
  logic        dec_iter_en, dec_iter_en1;
  logic [2:0]  dec_iter_idx, dec_iter_idx1;
  logic [43:0] dec_hard, dec_hard1;
  logic        out_valid, out_valid1;
  logic [43:0] out_cw, out_cw1;
  logic [2:0]  out_iters, out_iters1;
  logic        out_converged, out_converged1;

  int ntest = 0;
  int nfail = 0;
  int n_init = 0;
  int n_en = 0;

  always #5 clk = ~clk;

  assign dec_hard  = dec_cw ^ hmask;
  assign dec_hard1 = dec_cw1 ^ hmask;

  llr_decode_ctrl #(
    .N_V (44), .N_ITER (5), .EARLY_STOP (1'b1)
  ) u0 (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready), .in_cw (in_cw),
    .dec_cw (dec_cw), .dec_init (dec_init),
    .dec_iter_en (dec_iter_en), .dec_iter_idx (dec_iter_idx),
    .dec_hard (dec_hard), .dec_syn_ok (dec_syn_ok),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_cw (out_cw), .out_iters (out_iters),
    .out_converged (out_converged)
  );

  llr_decode_ctrl #(
    .N_V (44), .N_ITER (5), .EARLY_STOP (1'b0)
  ) u1 (
    .clk (clk), .rst (rst),
    .in_valid (in_valid1), .in_ready (in_ready1), .in_cw (in_cw),
    .dec_cw (dec_cw1), .dec_init (dec_init1),
    .dec_iter_en (dec_iter_en1), .dec_iter_idx (dec_iter_idx1),
    .dec_hard (dec_hard1), .dec_syn_ok (dec_syn_ok),
    .out_valid (out_valid1), .out_ready (out_ready1),
    .out_cw (out_cw1), .out_iters (out_iters1),
    .out_converged (out_converged1)
  );

  always @(posedge clk) begin
    if (dec_init)    n_init <= n_init + 1;
    if (dec_iter_en) n_en   <= n_en + 1;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    ntest++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [43:0] wv [4];
    int i0, e0, got;
    bit pend;

    rst = 1'b0; in_valid = 0; in_valid1 = 0; in_cw = '0;
    dec_syn_ok = 0; out_ready = 0; out_ready1 = 1; hmask = '0;

    // Reset state
    step;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dec_cw", dec_cw, 0);
    chk("rst_out_iters", out_iters, 0);
    chk("rst_init_en", {dec_init, dec_iter_en}, 0);
    rst = 1'b1;
    step;
    chk("rel_in_ready", in_ready, 1);

    // Already-valid codeword: zero iterations
    dec_syn_ok = 1; hmask = 44'h123; in_cw = 44'h0; in_valid = 1;
    i0 = n_init; e0 = n_en;
    step;
    in_valid = 0;
    chk("t1_no_ov", out_valid, 0);
    step;
    chk("t1_init", dec_init, 1);
    step;
    chk("t1_init_off", dec_init, 0);
    chk("t1_no_en", dec_iter_en, 0);
    step;
    chk("t1_ov", out_valid, 1);
    chk("t1_iters", out_iters, 0);
    chk("t1_conv", out_converged, 1);
    chk("t1_cw", out_cw, 44'h123);
    chk("t1_ninit", n_init - i0, 1);
    chk("t1_nen", n_en - e0, 0);
    out_ready = 1;
    step;
    out_ready = 0;
    chk("t1_ov_drop", out_valid, 0);

    // Never converges: full N_ITER iterations
    dec_syn_ok = 0; hmask = 44'hABC_DEF; in_cw = 44'h5A5; in_valid = 1;
    e0 = n_en;
    step;
    in_valid = 0;
    step;
    chk("t2_init", dec_init, 1);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("t2_en", dec_iter_en, 1);
      chk("t2_idx", dec_iter_idx, i);
    end
    step;
    chk("t2_cap_no_en", dec_iter_en, 0);
    step;
    chk("t2_ov", out_valid, 1);
    chk("t2_iters", out_iters, 5);
    chk("t2_conv", out_converged, 0);
    chk("t2_cw", out_cw, 44'h5A5 ^ 44'hABC_DEF);
    chk("t2_dec_cw", dec_cw, 44'h5A5);
    chk("t2_nen", n_en - e0, 5);
    out_ready = 1;
    step;
    out_ready = 0;

    // Syndrome satisfied after 2 iterations, early stop on and off
    dec_syn_ok = 0; hmask = 44'h0F0; in_cw = 44'h777;
    in_valid = 1; in_valid1 = 1;
    step;
    in_valid = 0; in_valid1 = 0;
    step;
    step;
    step;
    step;
    chk("t3_idx2", dec_iter_idx, 2);
    chk("t3_en2", dec_iter_en, 1);
    dec_syn_ok = 1;
    #1;
    chk("t3_stop", dec_iter_en, 0);
    chk("t3_nostop", dec_iter_en1, 1);
    step;
    chk("t3_ov", out_valid, 1);
    chk("t3_iters", out_iters, 2);
    chk("t3_conv", out_converged, 1);
    step;
    step;
    step;
    chk("t3_ov1", out_valid1, 1);
    chk("t3_iters1", out_iters1, 5);
    chk("t3_conv1", out_converged1, 1);
    chk("t3_cw1", out_cw1, 44'h777 ^ 44'h0F0);
    out_ready = 1;
    step;
    out_ready = 0;

    // Back-to-back pushes under downstream stall
    dec_syn_ok = 1; hmask = 44'h3C;
    wv[0] = 44'h100_0000_0001;
    wv[1] = 44'h200_0000_0002;
    wv[2] = 44'h300_0000_0003;
    wv[3] = 44'h400_0000_0004;
    in_valid = 1; in_cw = wv[0];
    chk("t4_rdy1", in_ready, 1);
    step;
    in_cw = wv[1];
    chk("t4_rdy2", in_ready, 1);
    step;
    in_cw = wv[2];
    chk("t4_rdy3", in_ready, 1);
    step;
    in_cw = wv[3];
    chk("t4_rdy_drop", in_ready, 0);
    step;
    chk("t4_ov", out_valid, 1);
    chk("t4_full", in_ready, 0);
    step;
    step;
    chk("t4_hold_ov", out_valid, 1);
    chk("t4_hold_cw", out_cw, wv[0] ^ 44'h3C);
    chk("t4_hold_full", in_ready, 0);
    out_ready = 1;
    got = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      pend = in_valid && in_ready;
      if (out_valid) begin
        chk("t4_res_cw", out_cw, wv[got] ^ 44'h3C);
        chk("t4_res_dec_cw", dec_cw, wv[got]);
        got++;
      end
      step;
      if (pend) in_valid = 0;
    end
    chk("t4_nres", got, 4);
    chk("t4_d_pushed", in_valid, 0);
    out_ready = 0;

    // Reset during ITER, then clean restart
    dec_syn_ok = 0; hmask = 44'h5; in_cw = 44'hBAD; in_valid = 1;
    step;
    in_valid = 0;
    step;
    step;
    step;
    chk("t5_in_iter", dec_iter_en, 1);
    rst = 1'b0;
    #1;
    chk("t5_ov", out_valid, 0);
    chk("t5_en", dec_iter_en, 0);
    chk("t5_init", dec_init, 0);
    chk("t5_dec_cw", dec_cw, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_outs", {out_cw, out_iters, out_converged}, 0);
    step;
    rst = 1'b1;
    step;
    chk("t5_rel_rdy", in_ready, 1);
    dec_syn_ok = 1; in_cw = 44'hC0DE; in_valid = 1;
    step;
    in_valid = 0;
    chk("t5_no_stale0", out_valid, 0);
    step;
    chk("t5_no_stale1", out_valid, 0);
    step;
    chk("t5_no_stale2", out_valid, 0);
    step;
    chk("t5_ov_new", out_valid, 1);
    chk("t5_dec_cw_new", dec_cw, 44'hC0DE);
    chk("t5_cw_new", out_cw, 44'hC0DE ^ 44'h5);
    chk("t5_iters_new", out_iters, 0);
    out_ready = 1;
    step;
    out_ready = 0;
    chk("t5_done", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/llr_decode_ctrl.md
# llr_decode_ctrl

Sequencing controller for the min-sum decoding datapath. It accepts hard-decision codewords from the upstream source over a valid/ready handshake and buffers them in a 2-entry FIFO. It presents one codeword at a time on the bit-to-LLR converter's `cw` input, pulses the decoder's initialisation strobe, and issues iteration enables up to `N_ITER` or until early termination on a satisfied syndrome. It then returns the decoded word, iteration count and convergence flag downstream over a second valid/ready handshake.

## Interface
- `N_V`, 44, codeword length (variable nodes)
- `N_ITER`, 5, maximum decoder iterations, ≥1
- `EARLY_STOP`, 1, 1 = terminate when `dec_syn_ok` is high
- `clk`  in  1  single clock, rising-edge
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `in_valid`  in  1  upstream codeword valid
- `in_ready`  out  1  FIFO can accept
- `in_cw`  in  N_V  hard-decision codeword
- `dec_cw`  out  N_V  codeword driven to the bit-to-LLR converter
- `dec_init`  out  1  one-cycle strobe: decoder loads LLRs from `dec_cw`
- `dec_iter_en`  out  1  decoder performs one iteration this cycle
- `dec_iter_idx`  out  $clog2(N_ITER+1)  index of current iteration (0-based)
- `dec_hard`  in  N_V  decoder's current hard decision
- `dec_syn_ok`  in  1  all parity checks satisfied by `dec_hard`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts
- `out_cw`  out  N_V  decoded codeword
- `out_iters`  out  $clog2(N_ITER+1)  iterations executed
- `out_converged`  out  1  `dec_syn_ok` at capture

## Operation
- FIFO: 2 entries, registered count. Push on `in_valid && in_ready`. `in_ready = !full`, forced 0 while `rst` is low.
- Push and pop in the same cycle are both honoured. Count is unchanged in that case.
- A push while full is impossible (ready low). No pass-through from an empty FIFO.
- States: IDLE, INIT, ITER, OUT.
- IDLE: if the FIFO is non-empty, pop the head into the `dec_cw` register and go to INIT. Otherwise stay.
- INIT (1 cycle): `dec_init=1`, clear `iter_cnt`, go to ITER.
- ITER: the terminate condition is `iter_cnt==N_ITER || (EARLY_STOP && dec_syn_ok)`.
  - If terminate: `dec_iter_en=0`; capture `out_cw<=dec_hard`, `out_iters<=iter_cnt`, `out_converged<=dec_syn_ok`; go to OUT.
  - Else: `dec_iter_en=1`, `iter_cnt++`.
- `dec_syn_ok` is sampled in the first ITER cycle as well. An input codeword that is already valid terminates with `out_iters=0`.
- OUT: `out_valid=1`. Outputs are held stable until `out_ready`. On handshake, go to IDLE.
- `dec_iter_idx = iter_cnt`. It is meaningful only while `dec_iter_en` is high.
- `dec_cw` is stable from INIT through OUT. It changes only on a pop.
- With `EARLY_STOP=0`, `dec_syn_ok` is used only for `out_converged`.

## Timing
- Reset (async assert, sync release inside the block's flops):
  - state=IDLE, FIFO empty.
  - `dec_cw`, `out_cw`, `out_iters`, `iter_cnt` = 0.
  - `dec_init`, `dec_iter_en`, `out_valid`, `out_converged` = 0.
  - `in_ready`=0 while `rst` is low, and 1 from the first cycle after release.
- Reset mid-operation aborts immediately. FIFO contents and the in-flight result are discarded, with no partial `out_valid`.
- Latency, push accepted at edge t with FIFO empty and state IDLE:
  - IDLE pops at edge t+1.
  - `dec_init` is high during cycle t+1..t+2.
  - The first ITER cycle starts at t+2.
  - k iterations occupy k enable cycles plus 1 capture cycle.
  - `out_valid` rises at edge t+3+k.
- Throughput: one bubble cycle (IDLE) between results. While decoding, the FIFO accepts up to 2 further words.
- `dec_init`, `dec_iter_en` and `out_*` are registered or state-decoded. No combinational path exists from `out_ready` to `in_ready`.
- Downstream stall: the FSM holds OUT indefinitely. The FIFO fills, then `in_ready=0`.

## Structure
- Package `llr_ctrl_pkg` holds:
  - the `ctrl_state_t` enum (IDLE, INIT, ITER, OUT);
  - a function `iter_w(N_ITER)` returning $clog2(N_ITER+1);
  - default `N_V`/`N_ITER` constants shared with the converter and decoder.
- Sub-module `cw_fifo` (param `W`, depth 2): push/pop/full/empty/head.
- The FSM and capture registers live in the top.

## Test plan
- Single word `in_cw=44'h0`, `dec_syn_ok=1` tied:
  - `dec_init` pulses once;
  - no `dec_iter_en`;
  - `out_valid` arrives 3 cycles after push with `out_iters=0`, `out_converged=1`.
- Word with `dec_syn_ok=0` always, `N_ITER=5`:
  - exactly 5 `dec_iter_en` cycles, `dec_iter_idx` 0..4;
  - `out_iters=5`, `out_converged=0`, `out_cw=dec_hard` at capture.
- `dec_syn_ok` rising after 2 iterations with `EARLY_STOP=1`: `out_iters=2`, `out_converged=1`. Same stimulus with `EARLY_STOP=0`: `out_iters=5`.
- Back-to-back 4 pushes with `out_ready=0`:
  - pushes 1–3 accepted;
  - `in_ready` drops after the third;
  - releasing `out_ready` yields results in order with the correct `dec_cw` for each.
- Assert `rst` low during ITER: all outputs are 0 immediately. After release, a new push decodes normally and no stale result appears.
